// File: rtl/spi_ip_pkg.sv
// Shared types, widths and helpers for the SPI shift engine.
package spi_ip_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned DIV_WIDTH  = 16;
    localparam int unsigned CNT_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Frame length N: 0 or anything above DATA_WIDTH selects a full word.
    function automatic logic [CNT_WIDTH-1:0] eff_bits(input logic [CNT_WIDTH-1:0] xfer_bits);
        if ((xfer_bits == '0) || (xfer_bits > CNT_WIDTH'(DATA_WIDTH)))
            return CNT_WIDTH'(DATA_WIDTH);
        return xfer_bits;
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Register-block / pin bundle between the SPI register bank and the shift engine.
interface spi_shift_engine_if;
    import spi_ip_pkg::*;

    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic [CNT_WIDTH-1:0]  xfer_bits;
    logic [DIV_WIDTH-1:0]  clk_div;
    logic                  cpol;
    logic                  cpha;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        output start, tx_data, xfer_bits, clk_div, cpol, cpha, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        input  start, tx_data, xfer_bits, clk_div, cpol, cpha, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: pulses tick once every div+1 enabled cycles.
module spi_half_tick
    import spi_ip_pkg::*;
(
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_cnt;

    // Held at the reload value while disabled so a new frame starts a full half-period.
    always_ff @(posedge ACLK) begin
        if (ARESET)
            r_cnt <= '0;
        else if (!en || (r_cnt == '0))
            r_cnt <= div;
        else
            r_cnt <= r_cnt - DIV_WIDTH'(1);
    end

    assign tick = en && (r_cnt == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: all four CPOL/CPHA modes, 1..32-bit MSB-first frames.
module spi_shift_engine
    import spi_ip_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESET,
    spi_shift_engine_if.slave bus
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;
    logic [DIV_WIDTH-1:0]  r_div;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lead;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_cs_n;

    logic                  w_tick;
    logic                  w_en;
    logic [DIV_WIDTH-1:0]  w_div;
    logic [CNT_WIDTH-1:0]  w_n;
    logic [DATA_WIDTH-1:0] w_tx_al;

    assign w_en    = (r_state != IDLE);
    assign w_div   = (r_state == IDLE) ? bus.clk_div : r_div;
    assign w_n     = eff_bits(bus.xfer_bits);
    // Left-align the frame so the next bit to drive is always the MSB.
    assign w_tx_al = bus.tx_data << (CNT_WIDTH'(DATA_WIDTH) - w_n);

    spi_half_tick u_half_tick (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .en     (w_en),
        .div    (w_div),
        .tick   (w_tick)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_div     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lead    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= bus.cpol;
                    r_mosi <= 1'b0;
                    r_cs_n <= 1'b1;
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_state   <= SETUP;
                        r_cs_n    <= 1'b0;
                        r_busy    <= 1'b1;
                        r_div     <= bus.clk_div;
                        r_cpol    <= bus.cpol;
                        r_cpha    <= bus.cpha;
                        r_bit_cnt <= w_n;
                        r_rx      <= '0;
                        r_lead    <= 1'b1;
                        if (!bus.cpha) begin
                            r_mosi <= w_tx_al[DATA_WIDTH-1];
                            r_tx   <= w_tx_al << 1;
                        end else begin
                            r_tx   <= w_tx_al;
                        end
                    end
                end
                SETUP, SHIFT: begin
                    // The first tick out of SETUP is SCLK edge 1.
                    if (w_tick) begin
                        r_state <= SHIFT;
                        r_sclk  <= ~r_sclk;
                        r_lead  <= ~r_lead;
                        if (r_lead) begin
                            if (r_cpha) begin
                                r_mosi <= r_tx[DATA_WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end else begin
                                r_rx   <= {r_rx[DATA_WIDTH-2:0], bus.miso};
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt - CNT_WIDTH'(1);
                            if (r_cpha) begin
                                r_rx <= {r_rx[DATA_WIDTH-2:0], bus.miso};
                            end else if (r_bit_cnt != CNT_WIDTH'(1)) begin
                                r_mosi <= r_tx[DATA_WIDTH-1];
                                r_tx   <= r_tx << 1;
                            end
                            if (r_bit_cnt == CNT_WIDTH'(1))
                                r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_cs_n    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_mosi    <= 1'b0;
                        r_sclk    <= r_cpol;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed and random frames against a cycle-count / bit-list model of the SPI master.
module tb_spi_shift_engine;

    logic ACLK;
    logic ARESET;
    int   n_cmp;
    int   n_fail;

    spi_shift_engine_if bus_if ();

    spi_shift_engine dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus_if.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Runs one frame from the current cycle T; returns in the done cycle.
    task automatic run_frame(input logic [31:0] tx, input logic [5:0] xb, input logic [15:0] dv,
                             input logic pol, input logic pha, input logic [31:0] sw,
                             input bit disturb);
        int          n;
        int          h;
        int          t_done;
        int          edges;
        int          j;
        int          b;
        bit          finished;
        bit          is_sample;
        logic [31:0] mask;
        logic        prev_sclk;
        logic        prev_mosi;

        n      = ((xb == 6'd0) || (xb > 6'd32)) ? 32 : int'(xb);
        h      = int'(dv) + 1;
        t_done = 1 + (2 * n + 1) * h;
        mask   = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);

        bus_if.tx_data   = tx;
        bus_if.xfer_bits = xb;
        bus_if.clk_div   = dv;
        bus_if.cpol      = pol;
        bus_if.cpha      = pha;
        bus_if.miso      = pha ? 1'b0 : sw[n-1];
        bus_if.start     = 1'b1;
        step();
        bus_if.start     = 1'b0;
        j = 1;

        chk("cs_low_at_T1", 32'(bus_if.cs_n), 32'd0);
        chk("busy_at_T1", 32'(bus_if.busy), 32'd1);
        chk("sclk_idle_level", 32'(bus_if.sclk), 32'(pol));
        if (!pha) chk("mosi_first_bit", 32'(bus_if.mosi), 32'(tx[n-1]));

        prev_sclk = bus_if.sclk;
        prev_mosi = bus_if.mosi;
        edges     = 0;
        finished  = 1'b0;

        while (!finished && (j < t_done + 4)) begin
            if (disturb && (j == 10)) begin
                bus_if.start   = 1'b1;
                bus_if.tx_data = ~tx;
                bus_if.clk_div = dv + 16'd3;
            end else begin
                bus_if.start = 1'b0;
            end
            step();
            j++;

            if (bus_if.sclk !== prev_sclk) begin
                edges++;
                chk("edge_time", 32'(j), 32'(1 + edges * h));
                is_sample = pha ? (edges % 2 == 0) : (edges % 2 == 1);
                if (is_sample) begin
                    b = (edges - 1) / 2;
                    if (b < n) chk("mosi_bit", 32'(prev_mosi), 32'(tx[n-1-b]));
                end
            end

            b = pha ? ((edges == 0) ? 0 : (edges - 1) / 2) : (edges / 2);
            if (b < n) bus_if.miso = sw[n-1-b];

            if (bus_if.done === 1'b1) begin
                finished = 1'b1;
                chk("done_time", 32'(j), 32'(t_done));
                chk("rx_data", bus_if.rx_data, sw & mask);
                chk("busy_at_done", 32'(bus_if.busy), 32'd0);
                chk("cs_high_at_done", 32'(bus_if.cs_n), 32'd1);
                chk("mosi_at_done", 32'(bus_if.mosi), 32'd0);
                chk("edge_count", 32'(edges), 32'(2 * n));
                chk("sclk_at_done", 32'(bus_if.sclk), 32'(pol));
            end
            prev_sclk = bus_if.sclk;
            prev_mosi = bus_if.mosi;
        end
        bus_if.start = 1'b0;
        if (!finished) chk("done_seen", 32'd0, 32'd1);
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        ARESET           = 1'b1;
        bus_if.start     = 1'b0;
        bus_if.tx_data   = '0;
        bus_if.xfer_bits = '0;
        bus_if.clk_div   = '0;
        bus_if.cpol      = 1'b1;
        bus_if.cpha      = 1'b0;
        bus_if.miso      = 1'b0;
        repeat (3) step();

        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_rx", bus_if.rx_data, 32'd0);
        chk("rst_sclk", 32'(bus_if.sclk), 32'd0);
        chk("rst_mosi", 32'(bus_if.mosi), 32'd0);
        chk("rst_cs_n", 32'(bus_if.cs_n), 32'd1);

        ARESET = 1'b0;
        step();
        chk("idle_sclk_follows_cpol", 32'(bus_if.sclk), 32'd1);
        bus_if.cpol = 1'b0;
        step();

        // Mode 0, N=8, H=2, looped back
        run_frame(32'h0000_00A5, 6'd8, 16'd1, 1'b0, 1'b0, 32'h0000_00A5, 1'b0);
        step();
        chk("done_single_s1", 32'(bus_if.done), 32'd0);

        // Mode 3, full word, H=1
        run_frame(32'hDEAD_BEEF, 6'd0, 16'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
        step();

        // Mode 1, N=5, H=4, miso tied high
        run_frame(32'h0000_0015, 6'd5, 16'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step();

        // Mode 0 with start re-pulse and config change mid-frame
        run_frame(32'h0000_00A5, 6'd8, 16'd1, 1'b0, 1'b0, 32'h0000_003C, 1'b1);
        step();
        chk("done_single_s4", 32'(bus_if.done), 32'd0);
        chk("busy_after_s4", 32'(bus_if.busy), 32'd0);

        // Reset at T+12 of a mode-0 frame
        bus_if.tx_data   = 32'h0000_00A5;
        bus_if.xfer_bits = 6'd8;
        bus_if.clk_div   = 16'd1;
        bus_if.cpol      = 1'b0;
        bus_if.cpha      = 1'b0;
        bus_if.start     = 1'b1;
        step();
        bus_if.start = 1'b0;
        repeat (11) step();
        chk("busy_before_reset", 32'(bus_if.busy), 32'd1);
        ARESET = 1'b1;
        step();
        chk("abort_cs_n", 32'(bus_if.cs_n), 32'd1);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        chk("abort_sclk", 32'(bus_if.sclk), 32'd0);
        chk("abort_rx", bus_if.rx_data, 32'd0);
        chk("abort_done", 32'(bus_if.done), 32'd0);
        ARESET = 1'b0;
        step();
        chk("abort_no_done", 32'(bus_if.done), 32'd0);
        run_frame(32'h0000_005A, 6'd8, 16'd1, 1'b0, 1'b0, 32'h0000_00C3, 1'b0);
        step();

        // Clamped length, back-to-back start on the done cycle
        run_frame(32'hCAFE_F00D, 6'd40, 16'd0, 1'b0, 1'b0, 32'h8765_4321, 1'b0);
        run_frame(32'h0BAD_C0DE, 6'd40, 16'd1, 1'b1, 1'b0, 32'hA5A5_0F0F, 1'b0);
        step();

        // Random frames
        for (int i = 0; i < 8; i++) begin
            run_frame($urandom, 6'($urandom_range(0, 40)), 16'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
            repeat (int'($urandom_range(0, 2))) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
